// File: rtl/gpu_cmd_scheduler.sv
// Command FIFO between writeback and the rasteriser; dispatches one command at a
// time, only during video blanking, and back-pressures the CPU pipeline when nearly full.
module gpu_cmd_scheduler #(
    parameter int unsigned GSR_W = 16,
    parameter int unsigned VTX_W = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         I_CLK,
    input  logic                         I_RST,
    input  logic [GSR_W-1:0]             I_GSRValue,
    input  logic                         I_GSRValue_Valid,
    input  logic [VTX_W-1:0]             I_VertexV1,
    input  logic [VTX_W-1:0]             I_VertexV2,
    input  logic [VTX_W-1:0]             I_VertexV3,
    input  logic                         I_VIDEO_ON,
    input  logic                         I_RAST_READY,
    input  logic                         I_RAST_DONE,
    output logic                         O_RAST_VALID,
    output logic [GSR_W-1:0]             O_RAST_GSR,
    output logic [VTX_W-1:0]             O_RAST_V1,
    output logic [VTX_W-1:0]             O_RAST_V2,
    output logic [VTX_W-1:0]             O_RAST_V3,
    output logic                         O_RAST_HOLD,
    output logic                         O_GPUStallSignal,
    output logic                         O_OVERFLOW,
    output logic [$clog2(DEPTH):0]       O_COUNT,
    output logic                         O_IDLE
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [GSR_W-1:0] gsr;
        logic [VTX_W-1:0] v1;
        logic [VTX_W-1:0] v2;
        logic [VTX_W-1:0] v3;
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY} state_t;

    state_t             state_q, state_d;
    cmd_t               mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               push, pop;
    cmd_t               cmd_in, head;

    assign cmd_in = '{gsr: I_GSRValue, v1: I_VertexV1, v2: I_VertexV2, v3: I_VertexV3};
    assign head   = mem_q[rd_ptr_q];

    // Full is judged after a same-cycle pop, so a full FIFO still accepts while draining.
    always_comb begin
        pop        = (state_q == S_ISSUE) && I_RAST_READY;
        push       = I_GSRValue_Valid && ((count_q != CNT_W'(DEPTH)) || pop);
        wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        overflow_d = overflow_q | (I_GSRValue_Valid & ~push);
        count_d    = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Dispatch only in blanking; a ready handshake wins over video turning on.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if ((count_q != '0) && !I_VIDEO_ON) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (I_RAST_READY) begin
                    state_d = S_BUSY;
                end else if (I_VIDEO_ON) begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                if (I_RAST_DONE) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                mem_q[wr_ptr_q] <= cmd_in;
            end
        end
    end

    assign O_RAST_VALID     = (state_q == S_ISSUE);
    assign O_RAST_GSR       = head.gsr;
    assign O_RAST_V1        = head.v1;
    assign O_RAST_V2        = head.v2;
    assign O_RAST_V3        = head.v3;
    // Hold reacts to video in the same cycle so SRAM scan-out is never contended.
    assign O_RAST_HOLD      = (state_q == S_BUSY) && I_VIDEO_ON;
    assign O_GPUStallSignal = (count_q >= CNT_W'(DEPTH - 1));
    assign O_OVERFLOW       = overflow_q;
    assign O_COUNT          = count_q;
    assign O_IDLE           = (state_q == S_IDLE) && (count_q == '0);

endmodule

// File: doc/gpu_cmd_scheduler.md
# gpu_cmd_scheduler

Buffers graphics commands (GSR value plus three vertices) retired by the CPU writeback stage and dispatches them one at a time to the rasterisation stage. It sits between the writeback stage and the rasteriser/GPU, launching work only during video blanking so the rasteriser never contends with VGA scan-out for the framebuffer SRAM. It generates the pipeline-wide GPU stall signal that back-pressures Fetch through Writeback.

## Interface
- GSR_W, 16, width of the GSR command value
- VTX_W, 32, width of one vertex register
- DEPTH, 4, command FIFO entries; power of two, minimum 2
- I_CLK  in  1  system clock (pll_c0 domain)
- I_RST  in  1  asynchronous, active-high reset
- I_GSRValue  in  GSR_W  command value from writeback
- I_GSRValue_Valid  in  1  push strobe; one command per high cycle
- I_VertexV1 / I_VertexV2 / I_VertexV3  in  VTX_W each  vertex operands, sampled with I_GSRValue
- I_VIDEO_ON  in  1  high while VGA is in the active display region
- I_RAST_READY  in  1  rasteriser accepts the presented command
- I_RAST_DONE  in  1  single-cycle pulse when the rasteriser finishes the current command
- O_RAST_VALID  out  1  command presented to rasteriser
- O_RAST_GSR  out  GSR_W  FIFO head GSR value
- O_RAST_V1 / O_RAST_V2 / O_RAST_V3  out  VTX_W each  FIFO head vertices
- O_RAST_HOLD  out  1  rasteriser must pause SRAM writes
- O_GPUStallSignal  out  1  stall to all CPU pipeline stages
- O_OVERFLOW  out  1  sticky: a push was dropped
- O_COUNT  out  log2(DEPTH)+1  FIFO occupancy
- O_IDLE  out  1  FIFO empty and no command in flight

## Operation
- FIFO: circular buffer of {GSR, V1, V2, V3}; write and read pointers of log2(DEPTH) bits wrap modulo DEPTH; count register 0..DEPTH.
- Push: at the clock edge where I_GSRValue_Valid=1 and count<DEPTH. When count==DEPTH the push is discarded, FIFO contents are unchanged and O_OVERFLOW is set; O_OVERFLOW clears only on reset.
- Pop: at the edge where O_RAST_VALID=1 and I_RAST_READY=1.
- Simultaneous push and pop: both take effect; count unchanged. A push into a full FIFO with a simultaneous pop is accepted, because full is evaluated after the pop.
- O_RAST_GSR/V1..V3 always show the head entry. They are undefined-but-stable when the FIFO is empty.
- FSM states:
  - IDLE: go to ISSUE when count!=0 and I_VIDEO_ON=0.
  - ISSUE: O_RAST_VALID=1. If I_RAST_READY=1, pop and go to BUSY; this has priority over I_VIDEO_ON. Else if I_VIDEO_ON=1, withdraw and go to IDLE with the entry retained. Else stay in ISSUE with the payload stable.
  - BUSY: go to IDLE on I_RAST_DONE=1. I_RAST_DONE in any other state is ignored.
- O_RAST_HOLD = (state==BUSY) & I_VIDEO_ON. It is combinational, so the rasteriser halts in the same cycle video turns on.
- O_GPUStallSignal = (count >= DEPTH-1). It is registered-input combinational, which leaves one slot of slack for a command already in the Writeback latch.
- O_IDLE = (state==IDLE) & (count==0).

## Timing
- Reset (asynchronous, immediate): state IDLE, pointers 0, count 0. O_RAST_VALID=0, O_RAST_HOLD=0, O_GPUStallSignal=0, O_OVERFLOW=0, O_COUNT=0, O_IDLE=1. Payload outputs are 0.
- Reset asserted mid-operation (ISSUE or BUSY) discards all queued and in-flight commands. The rasteriser is expected to be reset by the same signal.
- Push-to-valid latency into an empty FIFO with I_VIDEO_ON=0: push at edge N; count=1 after N; FSM enters ISSUE at edge N+1; O_RAST_VALID high during cycle N+1..N+2.
- Handshake completes on the edge where O_RAST_VALID and I_RAST_READY are both high. O_RAST_VALID is low in the following cycle (BUSY).
- DONE to next ISSUE: I_RAST_DONE at edge M gives IDLE after M. The next ISSUE is at M+1 if the dispatch conditions hold, giving a 2-cycle minimum between commands.
- O_COUNT and O_GPUStallSignal update the cycle after the push/pop edge.

## Test plan
- Reset during ISSUE with 2 entries queued: assert I_RST -> same cycle O_RAST_VALID=0, O_COUNT=0, O_IDLE=1. After release, no dispatch occurs without a new push.
- Single command: push GSR=0x0003, V1=0x00100020 with I_VIDEO_ON=0, and I_RAST_READY=1 from cycle 2 -> O_RAST_VALID high exactly one cycle later, payload matches, O_COUNT returns to 0. I_RAST_DONE 10 cycles later -> O_IDLE=1.
- Blanking gate: queue 1 command with I_VIDEO_ON=1 -> O_RAST_VALID stays 0. Drop I_VIDEO_ON -> O_RAST_VALID=1 the next cycle. Raise I_VIDEO_ON while I_RAST_READY=0 -> O_RAST_VALID=0 the next cycle and O_COUNT stays 1.
- Fill and overflow (DEPTH=4, I_VIDEO_ON=1): push 5 distinct commands -> O_GPUStallSignal=1 once O_COUNT=3, O_COUNT saturates at 4, O_OVERFLOW=1. Draining then delivers exactly the first 4 commands in order.
- Simultaneous push and pop at count=4 in ISSUE with I_RAST_READY=1 -> push accepted, O_OVERFLOW stays 0, O_COUNT=4.
- Hold: in BUSY, toggle I_VIDEO_ON 0→1→0 -> O_RAST_HOLD follows I_VIDEO_ON in the same cycle, and the FSM stays in BUSY until I_RAST_DONE.
